seg_disp_arbiter: RTL and testbench

- Owns the 6-digit seven-segment driver's load interface (48-bit din, 6-bit mask, one-cycle load strobe) and shares it between two requesters.
- Message port (priority): the SPI flash controller posts status text such as "rd", "SPN" or "PASS", which is shown for a fixed hold time.
- Data port: the flash read path posts a 24-bit value, shown as 6 hex digits with optional leading-zero blanking.
- When a message's hold time expires, the display reverts to the most recent data value.

---
 rtl/seg_disp_pkg.sv | 32 +++
 rtl/hex_to_seg_bytes.sv | 35 +++
 rtl/seg_disp_arbiter.sv | 140 ++++++++++++++
 tb/tb_seg_disp_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// ============================================================================
// Module   : seg_disp_pkg
// Brief    : Shared types and glyph constants for the six-digit display path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_DATA = 2'd1,
        ST_MSG  = 2'd2
    } state_e;

    localparam logic [7:0] GL_R     = "R";
    localparam logic [7:0] GL_D     = "D";
    localparam logic [7:0] GL_P     = "P";
    localparam logic [7:0] GL_N     = "N";
    localparam logic [7:0] GL_S     = "S";
    localparam logic [7:0] GL_BLANK = 8'hFF;

    localparam logic [5:0] MASK_ALL = 6'h3F;

    // Hex digits 0-F use their own value as the glyph code.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        return {4'h0, nib};
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg_bytes.sv
// ============================================================================
// Module   : hex_to_seg_bytes
// Brief    : Expands a 24-bit value into six hex glyph bytes plus a
//            leading-zero blanking mask (digit 0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg_bytes
    import seg_disp_pkg::*;
(
    input  logic [23:0] value,
    input  logic        lz_en,
    output logic [47:0] glyphs,
    output logic [5:0]  lz_mask
);

    logic lead_zero;

    always_comb begin
        glyphs    = '0;
        lz_mask   = '0;
        lead_zero = lz_en;
        for (int i = 5; i >= 0; i--) begin
            glyphs[8*i +: 8] = hex_glyph(value[4*i +: 4]);
            if (i > 0) begin
                lead_zero  = lead_zero & (value[4*i +: 4] == 4'h0);
                lz_mask[i] = lead_zero;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_disp_arbiter.sv
// ============================================================================
// Module   : seg_disp_arbiter
// Brief    : Shares the seven-segment driver load port between a priority
//            message requester and a hex data requester with timed revert.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 50_000_000,
    parameter bit          LZ_BLANK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_vld,
    input  logic [47:0] msg_din,
    input  logic [5:0]  msg_mask,
    output logic        msg_rdy,
    input  logic        data_vld,
    input  logic [23:0] data_val,
    output logic        data_rdy,
    output logic        msg_active,
    output logic [47:0] seg_din,
    output logic        seg_din_vld,
    output logic [5:0]  seg_din_mask
);

    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    state_e           state_q,     state_d;
    logic [23:0]      shadow_q,    shadow_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [47:0]      seg_din_q,   seg_din_d;
    logic [5:0]       seg_mask_q,  seg_mask_d;
    logic             seg_vld_q,   seg_vld_d;
    logic             msg_act_q,   msg_act_d;
    logic             msg_rdy_q,   msg_rdy_d;

    logic [23:0]      shadow_nxt;
    logic [47:0]      hex_glyphs;
    logic [5:0]       hex_mask;

    // Converting the post-update shadow lets a same-cycle data_vld be the
    // value shown, both in DATA and on message expiry.
    assign shadow_nxt = data_vld ? data_val : shadow_q;

    hex_to_seg_bytes u_hex (
        .value   (shadow_nxt),
        .lz_en   (LZ_BLANK_EN),
        .glyphs  (hex_glyphs),
        .lz_mask (hex_mask)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_nxt;
        hold_cnt_d = hold_cnt_q;
        seg_din_d  = seg_din_q;
        seg_mask_d = seg_mask_q;
        seg_vld_d  = 1'b0;
        msg_act_d  = msg_act_q;
        msg_rdy_d  = msg_rdy_q;

        case (state_q)
            ST_BOOT: begin
                seg_din_d  = '0;
                seg_mask_d = MASK_ALL;
                seg_vld_d  = 1'b1;
                msg_act_d  = 1'b0;
                msg_rdy_d  = 1'b1;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                if (msg_vld) begin
                    seg_din_d  = msg_din;
                    seg_mask_d = msg_mask;
                    seg_vld_d  = 1'b1;
                    msg_act_d  = 1'b1;
                    msg_rdy_d  = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = ST_MSG;
                end else if (data_vld) begin
                    seg_din_d  = hex_glyphs;
                    seg_mask_d = hex_mask;
                    seg_vld_d  = 1'b1;
                end
            end
            ST_MSG: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    seg_din_d  = hex_glyphs;
                    seg_mask_d = hex_mask;
                    seg_vld_d  = 1'b1;
                    msg_act_d  = 1'b0;
                    msg_rdy_d  = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            shadow_q   <= '0;
            hold_cnt_q <= '0;
            seg_din_q  <= '0;
            seg_mask_q <= MASK_ALL;
            seg_vld_q  <= 1'b0;
            msg_act_q  <= 1'b0;
            msg_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            hold_cnt_q <= hold_cnt_d;
            seg_din_q  <= seg_din_d;
            seg_mask_q <= seg_mask_d;
            seg_vld_q  <= seg_vld_d;
            msg_act_q  <= msg_act_d;
            msg_rdy_q  <= msg_rdy_d;
        end
    end

    assign msg_rdy      = msg_rdy_q;
    assign data_rdy     = 1'b1;
    assign msg_active   = msg_act_q;
    assign seg_din      = seg_din_q;
    assign seg_din_vld  = seg_vld_q;
    assign seg_din_mask = seg_mask_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_arbiter.sv
// ============================================================================
// Module   : tb_seg_disp_arbiter
// Brief    : Scoreboard bench for seg_disp_arbiter (HOLD_CYC = 20).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_disp_arbiter;

    localparam int HOLD = 20;

    logic        clk;
    logic        rst_n;
    logic        msg_vld;
    logic [47:0] msg_din;
    logic [5:0]  msg_mask;
    logic        msg_rdy;
    logic        data_vld;
    logic [23:0] data_val;
    logic        data_rdy;
    logic        msg_active;
    logic [47:0] seg_din;
    logic        seg_din_vld;
    logic [5:0]  seg_din_mask;

    seg_disp_arbiter #(
        .HOLD_CYC    (HOLD),
        .LZ_BLANK_EN (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_vld      (msg_vld),
        .msg_din      (msg_din),
        .msg_mask     (msg_mask),
        .msg_rdy      (msg_rdy),
        .data_vld     (data_vld),
        .data_val     (data_val),
        .data_rdy     (data_rdy),
        .msg_active   (msg_active),
        .seg_din      (seg_din),
        .seg_din_vld  (seg_din_vld),
        .seg_din_mask (seg_din_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] din;
        logic [5:0]  mask;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [47:0] model_din(input logic [23:0] v);
        logic [47:0] d;
        d = '0;
        for (int i = 0; i < 6; i++) d[8*i +: 8] = {4'h0, v[4*i +: 4]};
        return d;
    endfunction

    function automatic logic [5:0] model_mask(input logic [23:0] v);
        logic [5:0] m;
        m = '0;
        for (int i = 1; i < 6; i++) m[i] = ((v >> (4*i)) == 24'h0);
        return m;
    endfunction

    task automatic push_exp(input logic [47:0] d, input logic [5:0] m, input int c);
        exp_t e;
        e.din  = d;
        e.mask = m;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (seg_din_vld) begin
                check_val("strobe_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check_val("strobe_din", 64'(seg_din), 64'(mon_e.din));
                    check_val("strobe_mask", 64'(seg_din_mask), 64'(mon_e.mask));
                    check_val("strobe_cyc", 64'(cyc), 64'(mon_e.cyc));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                check_val("strobe_missing", 64'(seg_din_vld), 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic post_data(input logic [23:0] v, input logic [47:0] d, input logic [5:0] m);
        data_vld = 1'b1;
        data_val = v;
        push_exp(d, m, cyc + 1);
        step();
        data_vld = 1'b0;
    endtask

    // Holds msg_vld until the arbiter is ready; acc = cycle of acceptance.
    task automatic accept_msg(input logic [47:0] d, input logic [5:0] m, output int acc);
        int guard;
        msg_vld  = 1'b1;
        msg_din  = d;
        msg_mask = m;
        guard    = 0;
        while (!msg_rdy && guard < 200) begin
            step();
            guard++;
        end
        check_val("msg_rdy_wait", 64'(msg_rdy), 64'd1);
        acc = cyc;
        push_exp(d, m, cyc + 1);
        step();
        msg_vld = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_din"},    64'(seg_din), 64'h0);
        check_val({tag, "_mask"},   64'(seg_din_mask), 64'h3F);
        check_val({tag, "_vld"},    64'(seg_din_vld), 64'h0);
        check_val({tag, "_active"}, 64'(msg_active), 64'h0);
        check_val({tag, "_rdy"},    64'(msg_rdy), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [47:0] spn;
    logic [47:0] m2;
    logic [23:0] shadow;
    int a1, a2, act;

    initial begin
        rst_n    = 1'b0;
        msg_vld  = 1'b0;
        msg_din  = '0;
        msg_mask = '0;
        data_vld = 1'b0;
        data_val = '0;
        spn      = {"S", "P", "N", 8'hFF, 8'hFF, 8'hFF};
        m2       = {"P", "A", "S", "S", 8'hFF, 8'hFF};

        steps(3);
        check_reset_outputs("rst");
        check_val("data_rdy", 64'(data_rdy), 64'd1);

        rst_n = 1'b1;
        push_exp(48'h0, 6'h3F, cyc + 1);
        steps(6);
        check_val("idle_msg_rdy", 64'(msg_rdy), 64'd1);

        post_data(24'h00A05F, 48'h00_00_0A_00_05_0F, 6'b110000);
        step();
        post_data(24'h000000, 48'h00_00_00_00_00_00, 6'b111110);
        post_data(24'h000001, model_din(24'h000001), model_mask(24'h000001));
        post_data(24'hF00000, model_din(24'hF00000), model_mask(24'hF00000));
        post_data(24'h0ABCDE, model_din(24'h0ABCDE), model_mask(24'h0ABCDE));
        steps(3);

        // Message with a data update posted partway through the hold.
        accept_msg(spn, 6'h07, a1);
        act = 0;
        for (int i = 0; i < 30; i++) begin
            if (msg_active) act++;
            if (i == 5) begin
                check_val("hold_msg_rdy", 64'(msg_rdy), 64'd0);
                data_vld = 1'b1;
                data_val = 24'h123456;
                push_exp(48'h01_02_03_04_05_06, 6'h00, a1 + 1 + HOLD);
            end
            step();
            data_vld = 1'b0;
        end
        check_val("hold_active_cycles", 64'(act), 64'(HOLD));
        check_val("revert_msg_rdy", 64'(msg_rdy), 64'd1);

        // Message and data together: the message wins, data shows on revert.
        shadow   = 24'h000ABC;
        data_vld = 1'b1;
        data_val = shadow;
        accept_msg(spn, 6'h07, a1);
        data_vld = 1'b0;
        push_exp(model_din(shadow), model_mask(shadow), a1 + 1 + HOLD);
        steps(HOLD + 3);

        // A second message is held off until the first one expires.
        accept_msg(spn, 6'h07, a1);
        push_exp(model_din(shadow), model_mask(shadow), a1 + 1 + HOLD);
        accept_msg(m2, 6'h03, a2);
        check_val("msg2_accept_cyc", 64'(a2), 64'(a1 + 1 + HOLD));
        check_val("msg2_active", 64'(msg_active), 64'd1);
        push_exp(model_din(shadow), model_mask(shadow), a2 + 1 + HOLD);
        steps(HOLD + 3);

        // Asynchronous reset in the middle of a hold discards the message.
        accept_msg(m2, 6'h00, a1);
        steps(5);
        check_val("pre_reset_active", 64'(msg_active), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        steps(2);
        rst_n = 1'b1;
        push_exp(48'h0, 6'h3F, cyc + 1);
        steps(HOLD + 5);
        check_val("post_reset_active", 64'(msg_active), 64'd0);
        check_val("post_reset_rdy", 64'(msg_rdy), 64'd1);

        check_val("sb_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
